// File: rtl/mult4x4_seq_ctrl_if.sv
// mult4x4_seq_ctrl_if: request/grant/result bundle between two requesters
// and the shift-and-add multiplier sequencer.
//   master : requester side (drives req/operands, observes grant/result)
//   slave  : sequencer side (observes req/operands, drives grant/result)
interface mult4x4_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 req0;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic                 req1;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 grant0;
  logic                 grant1;
  logic                 busy;
  logic                 done;
  logic                 owner;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  grant0, grant1, busy, done, owner, product
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output grant0, grant1, busy, done, owner, product
  );
endinterface

// File: rtl/mult4x4_seq_ctrl.sv
// mult4x4_seq_ctrl: two-port round-robin arbiter in front of an iterative
// unsigned shift-and-add multiplier. One AND-gated partial product is added
// per ITER cycle; the product is published with a one-cycle done pulse.
// Optional feature macro: MULT_EARLY_EXIT_EN -- leave ITER as soon as the
// unconsumed multiplier bits are all zero, aligning the result in one step.
// All outputs come straight from registers.
module mult4x4_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mult4x4_seq_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]           state_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [WIDTH:0]       acc_r;
  logic [CW-1:0]        cnt_r;
  logic                 last_owner_r;
  logic                 owner_r;
  logic                 grant0_r;
  logic                 grant1_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic                 gnt0_s;
  logic                 gnt1_s;
  logic [WIDTH-1:0]     pp_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH:0]     shifted_s;
  logic [2*WIDTH:0]     final_s;
  logic                 last_iter_s;

`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     rem_next_s;
  logic [CW-1:0]        shamt_s;
`endif

  // Round-robin arbitration: only in IDLE; on a tie the requester that was not served last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == S_IDLE) begin
      if (bus.req0 && bus.req1) begin
        gnt0_s = last_owner_r;
        gnt1_s = ~last_owner_r;
      end else begin
        gnt0_s = bus.req0;
        gnt1_s = bus.req1;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // One shift-and-add step; the adder carry lands in acc's top bit and is shifted down into the result.
  always_comb begin
    pp_s      = mcand_r & {WIDTH{mplier_r[0]}};
    sum_s     = acc_r + {1'b0, pp_s};
    shifted_s = {sum_s, mplier_r} >> 1;
`ifdef MULT_EARLY_EXIT_EN
    rem_next_s = rem_r >> 1;
    if (rem_next_s == {WIDTH{1'b0}}) begin
      // Remaining iterations would only shift, so apply all of them now.
      shamt_s     = CNT_LAST - cnt_r;
      final_s     = shifted_s >> shamt_s;
      last_iter_s = 1'b1;
    end else begin
      shamt_s     = {CW{1'b0}};
      final_s     = shifted_s;
      last_iter_s = (cnt_r == CNT_LAST);
    end
`else
    final_s     = shifted_s;
    last_iter_s = (cnt_r == CNT_LAST);
`endif
  end

  // Sequencer state, operand capture, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      mcand_r      <= {WIDTH{1'b0}};
      mplier_r     <= {WIDTH{1'b0}};
      acc_r        <= {(WIDTH+1){1'b0}};
      cnt_r        <= {CW{1'b0}};
      last_owner_r <= 1'b1;
      owner_r      <= 1'b0;
      grant0_r     <= 1'b0;
      grant1_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      product_r    <= {(2*WIDTH){1'b0}};
`ifdef MULT_EARLY_EXIT_EN
      rem_r        <= {WIDTH{1'b0}};
`endif
    end else begin
      grant0_r <= gnt0_s;
      grant1_r <= gnt1_s;
      busy_r   <= (state_r != S_IDLE);
      done_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (gnt0_s || gnt1_s) begin
            mcand_r      <= gnt1_s ? bus.a1 : bus.a0;
            mplier_r     <= gnt1_s ? bus.b1 : bus.b0;
            acc_r        <= {(WIDTH+1){1'b0}};
            cnt_r        <= {CW{1'b0}};
            owner_r      <= gnt1_s;
            last_owner_r <= gnt1_s;
`ifdef MULT_EARLY_EXIT_EN
            rem_r        <= gnt1_s ? bus.b1 : bus.b0;
`endif
            state_r      <= S_ITER;
          end else begin
            state_r      <= S_IDLE;
          end
        end
        S_ITER: begin
          acc_r    <= final_s[2*WIDTH:WIDTH];
          mplier_r <= final_s[WIDTH-1:0];
          cnt_r    <= cnt_r + CNT_ONE;
`ifdef MULT_EARLY_EXIT_EN
          rem_r    <= rem_next_s;
`endif
          if (last_iter_s) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_ITER;
          end
        end
        S_DONE: begin
          product_r <= {acc_r[WIDTH-1:0], mplier_r};
          done_r    <= 1'b1;
          state_r   <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant0  = grant0_r;
  assign bus.grant1  = grant1_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.owner   = owner_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_mult4x4_seq_ctrl.sv
// Self-checking bench for mult4x4_seq_ctrl: directed scenarios followed by
// randomized requests, checked against a plain-arithmetic reference
// (product = a*b, round-robin winner, latency from the multiplier's top bit).
module tb_mult4x4_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult4x4_seq_ctrl_if #(.WIDTH(4)) bus ();

  mult4x4_seq_ctrl #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic       last_m;       // reference round-robin memory
  logic       exp_win;
  logic [7:0] exp_prod;
  int         exp_cycles;   // grant cycle to done cycle
  int         wcyc;
  bit         got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int m;
    m = 1;
    for (int i = 0; i < 4; i++) if (b[i]) m = i + 1;
    return m + 1;
`else
    return 5;
`endif
  endfunction

  task automatic wait_grant(input int budget, output bit g, output int w);
    int p;
    g = 1'b0;
    w = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.grant0 || bus.grant1) begin
        g = 1'b1;
        w = i;
        break;
      end
    end
    chk("grant_seen", g, 1);
    if (g) begin
      if (bus.req0 && bus.req1) exp_win = ~last_m;
      else                      exp_win = bus.req1;
      chk("grant0", bus.grant0, !exp_win);
      chk("grant1", bus.grant1, exp_win);
      chk("owner_at_grant", bus.owner, exp_win);
      chk("busy_at_grant", bus.busy, 0);
      last_m = exp_win;
      if (exp_win) begin
        p = int'(bus.a1) * int'(bus.b1);
        exp_cycles = lat(bus.b1);
      end else begin
        p = int'(bus.a0) * int'(bus.b0);
        exp_cycles = lat(bus.b0);
      end
      exp_prod = p[7:0];
    end
  endtask

  task automatic wait_done(input bit drop, input int raise1_at);
    bit seen;
    int obs_lat;
    seen    = 1'b0;
    obs_lat = 0;
    if (drop) begin
      if (exp_win) bus.req1 = 1'b0;
      else         bus.req0 = 1'b0;
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == raise1_at) bus.req1 = 1'b1;
      if (bus.done) begin
        seen    = 1'b1;
        obs_lat = i;
        break;
      end
      chk("busy_during_op", bus.busy, 1);
      chk("no_grant_during_op", {bus.grant0, bus.grant1}, 0);
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("latency", obs_lat, exp_cycles);
      chk("product", bus.product, exp_prod);
      chk("owner_at_done", bus.owner, exp_win);
      chk("busy_at_done", bus.busy, 1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = 4'h0;
    bus.b0   = 4'h0;
    bus.a1   = 4'h0;
    bus.b1   = 4'h0;
    last_m   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant0", bus.grant0, 0);
    chk("rst_grant1", bus.grant1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_owner", bus.owner, 0);

    // 15*15
    bus.a0 = 4'hF; bus.b0 = 4'hF; bus.req0 = 1'b1;
    wait_grant(4, got, wcyc);
    wait_done(1'b1, 0);
    chk("full_latency_F", exp_cycles, 5);
    @(negedge clk);
    chk("done_pulse_one_cycle", bus.done, 0);
    chk("product_hold", bus.product, 8'hE1);
    chk("busy_after_done", bus.busy, 0);

    // Tie after reset: requester 0 first, then 1, then alternation with held requests
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
    bus.a0 = 4'd3; bus.b0 = 4'd5; bus.a1 = 4'd7; bus.b1 = 4'd9;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_grant(4, got, wcyc);
    chk("tie_winner_first", exp_win, 0);
    wait_done(1'b1, 0);
    chk("prod_3x5", exp_prod, 8'h0F);
    wait_grant(4, got, wcyc);
    chk("second_grant_next_cycle", wcyc, 1);
    wait_done(1'b1, 0);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(4, got, wcyc);
      chk("alternate_order", exp_win, n % 2);
      wait_done(1'b0, 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Zero multiplier and single-bit multiplier
    bus.a0 = 4'h9; bus.b0 = 4'h0; bus.req0 = 1'b1;
    wait_grant(4, got, wcyc);
    wait_done(1'b1, 0);
    bus.a0 = 4'hA; bus.b0 = 4'h1; bus.req0 = 1'b1;
    wait_grant(4, got, wcyc);
    wait_done(1'b1, 0);
    chk("prod_Ax1", bus.product, 8'h0A);

    // req1 raised during ITER waits for IDLE: grant1 at T+6
    bus.a0 = 4'h3; bus.b0 = 4'h8; bus.a1 = 4'h5; bus.b1 = 4'h6;
    bus.req0 = 1'b1;
    wait_grant(4, got, wcyc);
    wait_done(1'b1, 2);
    wait_grant(4, got, wcyc);
    chk("late_req1_grant_T6", wcyc, 1);
    chk("late_req1_winner", exp_win, 1);
    wait_done(1'b1, 0);

    // Reset in the middle of an operation
    bus.a1 = 4'hF; bus.b1 = 4'hF; bus.req1 = 1'b1;
    wait_grant(4, got, wcyc);
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.a0 = 4'd2; bus.b0 = 4'd3; bus.a1 = 4'd4; bus.b1 = 4'd5;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    chk("abort_product", bus.product, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_owner", bus.owner, 0);
    chk("abort_done", bus.done, 0);
    rst = 1'b0;
    last_m = 1'b1;
    wait_grant(4, got, wcyc);
    chk("tie_after_abort", exp_win, 0);
    wait_done(1'b1, 0);
    wait_grant(4, got, wcyc);
    wait_done(1'b1, 0);

    // Randomized requests and operands
    for (int n = 0; n < 24; n++) begin
      if (!bus.req0 && ($urandom_range(1, 0) == 1)) begin
        bus.a0 = 4'($urandom_range(15, 0));
        bus.b0 = 4'($urandom_range(15, 0));
        bus.req0 = 1'b1;
      end
      if (!bus.req1 && ($urandom_range(1, 0) == 1)) begin
        bus.a1 = 4'($urandom_range(15, 0));
        bus.b1 = 4'($urandom_range(15, 0));
        bus.req1 = 1'b1;
      end
      if (!bus.req0 && !bus.req1) begin
        bus.a0 = 4'($urandom_range(15, 0));
        bus.b0 = 4'($urandom_range(15, 0));
        bus.req0 = 1'b1;
      end
      wait_grant(4, got, wcyc);
      wait_done(1'b1, 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Idle with no requests: no grants, no activity
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_grant", {bus.grant0, bus.grant1, bus.busy, bus.done}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
